uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_tick.sv | 39 +++
 rtl/uart_rx_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and bit-timing helper for the UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } rx_state_t;

    typedef struct packed {
        logic [31:0] total;
        logic [31:0] half;
    } bit_timing_t;

    // Bit period in clocks and the offset of the mid-bit sample point.
    function automatic bit_timing_t calc_bit_timing(input int unsigned clk_freq,
                                                    input int unsigned baud);
        bit_timing_t t;
        t.total = clk_freq / baud;
        t.half  = t.total / 2;
        return t;
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Bit-period counter for the UART receiver: runs while enabled, held at 0 otherwise,
// and flags the mid-bit and last-cycle points of each period.
module uart_rx_tick #(
    parameter int unsigned TOTAL = 1736,
    parameter int unsigned HALF  = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic mid_tick,
    output logic end_tick
);

    localparam int unsigned CNT_W = $clog2(TOTAL);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = '0;
        if (enable && (cnt != CNT_W'(TOTAL - 1))) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // Ticks are decoded from the next count so they are high while cnt holds that value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            mid_tick <= 1'b0;
            end_tick <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            mid_tick <= enable && (cnt_next == CNT_W'(HALF));
            end_tick <= enable && (cnt_next == CNT_W'(TOTAL - 1));
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchronizer, frame FSM and single-entry output register with ready/valid.
// Define UART_RX_PARITY_EN to receive 8 data bits + parity + stop; otherwise 8N1.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 200000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam bit_timing_t TIMING = calc_bit_timing(CLK_FREQ, BAUD);
    localparam int unsigned TOTAL  = TIMING.total;
    localparam int unsigned HALF   = TIMING.half;
    localparam int unsigned IDX_W  = $clog2(DATA_BITS);

    logic                 rxd_meta;
    logic                 rxd_s;
    logic                 rxd_prev;
    logic                 start_edge;
    rx_state_t            state;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 cnt_en;
    logic                 mid_tick;
    logic                 end_tick_unused;

    // Two-flop synchronizer plus one history flop for edge detection; resets to line idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    assign start_edge = rxd_prev & ~rxd_s;
    assign cnt_en     = (state != IDLE);

    uart_rx_tick #(
        .TOTAL (TOTAL),
        .HALF  (HALF)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .enable   (cnt_en),
        .mid_tick (mid_tick),
        .end_tick (end_tick_unused)
    );

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = 1'(PARITY_ODD);
    logic par_exp;
    logic par_err;
    assign par_exp = (^shift_reg) ^ PAR_ODD;
`else
    localparam logic PAR_ODD_UNUSED = 1'(PARITY_ODD);
    assign rx_parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_idx      <= '0;
            shift_reg    <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_busy      <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err       <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    bit_idx <= '0;
                    if (start_edge) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (mid_tick) begin
                        if (rxd_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (mid_tick) begin
                        shift_reg[bit_idx] <= rxd_s;
                        bit_idx            <= bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid_tick) begin
                        par_err <= (rxd_s != par_exp);
                        state   <= STOP;
                    end
                end
`endif
                // Leave at mid-stop so the next start edge is caught half a bit early.
                STOP: begin
                    if (mid_tick) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                        if (!rxd_s) begin
                            rx_frame_err <= 1'b1;
                        end else if (rx_valid && !rx_ready) begin
                            rx_overrun <= 1'b1;
                        end else begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            rx_parity_err <= par_err;
`endif
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
